if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the SWIS-V RISC-V pipeline.
- Holds the program counter and drives the instruction-memory request (strobe/address).
- Captures the returned instruction word and presents {o_pc, o_instr} to decode.
- Redirects the PC on taken branch/JAL (PC-relative) and JALR (register target) requests from execute.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on o_instr when no valid fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1).
- o_pc  out  32  PC of the instruction on o_instr.
- o_instr  out  32  fetched instruction to decode.
- i_inst  in  32  instruction word returned by instruction memory.
- i_imem_ack  in  1  memory has i_inst valid for current o_iaddr.
- o_imem_stb  out  1  fetch request strobe.
- o_iaddr  out  32  fetch address (current PC).
- i_imm  in  32  branch/JAL immediate, byte offset, two's complement.
- i_result  in  32  ALU result, JALR target.
- i_boj  in  1  taken branch or JAL: redirect to o_pc + i_imm.
- i_jalr  in  1  JALR: redirect to {i_result[31:1],1'b0}.

Behaviour:
- State:
  - pc register (32).
  - o_pc, o_instr, o_imem_stb registers.
  - All asynchronously reset while rst_n=1.
- Reset values:
  - pc=RESET_PC.
  - o_pc=RESET_PC.
  - o_instr=NOP_INSTR.
  - o_imem_stb=0.
- o_iaddr = pc, combinational, continuously; valid even while o_imem_stb=0.
- o_imem_stb: becomes 1 on the first rising edge after reset deasserts; stays 1 until next reset.
- Next-pc priority, evaluated each rising edge when out of reset:
  1. i_jalr=1 → pc ← {i_result[31:1],1'b0}.
  2. else i_boj=1 → pc ← o_pc + i_imm. Target is relative to the instruction currently in decode (o_pc), not the fetch PC.
  3. else o_imem_stb & i_imem_ack → pc ← pc + 4.
  4. else pc holds.
- Decode outputs on each rising edge:
  - Redirect (i_jalr|i_boj): o_instr ← NOP_INSTR; o_pc holds. The in-flight fetch is squashed even if ack=1.
  - Else o_imem_stb & i_imem_ack: o_instr ← i_inst, o_pc ← pc. One-cycle latency from address to decode.
  - Else (stall/wait): o_instr ← NOP_INSTR; o_pc holds.
- Arithmetic:
  - 32-bit modulo; pc+4 and o_pc+i_imm wrap silently at 2^32.
  - No alignment checks; bit0 is cleared only for JALR. Misaligned targets are fetched as-is.
- Simultaneous i_jalr and i_boj: JALR wins.
- Redirect while i_imem_ack=0: redirect still taken.
- Reset mid-operation: all state returns to reset values immediately (asynchronously), regardless of ack/redirect.

Test Plan:
- Reset:
  - Stimulus: rst_n=1 for 10 ns, then check.
  - Response: o_iaddr=0, o_pc=0, o_instr=0x00000013, o_imem_stb=0.
  - Stimulus: release rst_n.
  - Response: o_imem_stb=1 after the first edge.
- Sequential fetch:
  - Stimulus: i_imem_ack=1, i_inst=0x00106293, no redirects.
  - Response: o_iaddr steps 0,4,8,… per cycle; o_pc trails o_iaddr by one cycle; o_instr=0x00106293.
- Branch:
  - Stimulus: i_boj=1 for one cycle with o_pc=P, i_imm=0xC.
  - Response: next o_iaddr=P+0xC; o_instr=NOP for that cycle; o_pc unchanged.
  - Stimulus: i_boj held 2 cycles.
  - Response: second redirect is relative to the same held o_pc.
- JALR:
  - Stimulus: i_jalr=1, i_result=0xF.
  - Response: next o_iaddr=0xE; o_instr=NOP.
  - Stimulus: i_jalr=1 and i_boj=1 together.
  - Response: o_iaddr=0xE (JALR priority).
- Stall:
  - Stimulus: i_imem_ack=0 for 3 cycles.
  - Response: o_iaddr constant; o_instr=NOP; o_pc held.
  - Stimulus: ack returns.
  - Response: fetch resumes from the held address.
- Reset mid-run:
  - Stimulus: assert rst_n mid-cycle at o_iaddr=0x20.
  - Response: outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-fetch stage bus: imem request/response, decode outputs and execute redirects.
// master = fetch stage, slave = the surrounding pipeline/memory.
interface if_stage_if;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic [31:0] i_inst;
    logic        i_imem_ack;
    logic        o_imem_stb;
    logic [31:0] o_iaddr;
    logic [31:0] i_imm;
    logic [31:0] i_result;
    logic        i_boj;
    logic        i_jalr;

    modport master (
        output o_pc,
        output o_instr,
        output o_imem_stb,
        output o_iaddr,
        input  i_inst,
        input  i_imem_ack,
        input  i_imm,
        input  i_result,
        input  i_boj,
        input  i_jalr
    );

    modport slave (
        input  o_pc,
        input  o_instr,
        input  o_imem_stb,
        input  o_iaddr,
        output i_inst,
        output i_imem_ack,
        output i_imm,
        output i_result,
        output i_boj,
        output i_jalr
    );
endinterface

// File: rtl/if_stage.sv
// SWIS-V instruction-fetch stage: owns the PC, issues imem fetches and hands
// {pc, instr} to decode, redirecting on branch/JAL and JALR from execute.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    if_stage_if.master   bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] dec_pc_q;
    logic [31:0] dec_pc_d;
    logic [31:0] dec_instr_q;
    logic [31:0] dec_instr_d;
    logic        stb_q;

    logic        redirect;
    logic        fetch_fire;
    logic [31:0] jalr_target;
    logic [31:0] boj_target;

    assign redirect    = bus.i_jalr | bus.i_boj;
    assign fetch_fire  = stb_q & bus.i_imem_ack;
    assign jalr_target = bus.i_result & 32'hFFFF_FFFE;
    // Branch/JAL offsets are relative to the instruction in decode, not the fetch PC.
    assign boj_target  = dec_pc_q + bus.i_imm;

    always_comb begin
        pc_d = pc_q;
        if (bus.i_jalr) begin
            pc_d = jalr_target;
        end else if (bus.i_boj) begin
            pc_d = boj_target;
        end else if (fetch_fire) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        dec_pc_d    = dec_pc_q;
        dec_instr_d = NOP_INSTR;
        // A redirect squashes whatever the memory returns this cycle.
        if (!redirect && fetch_fire) begin
            dec_pc_d    = pc_q;
            dec_instr_d = bus.i_inst;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_q        <= RESET_PC;
            dec_pc_q    <= RESET_PC;
            dec_instr_q <= NOP_INSTR;
            stb_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            dec_pc_q    <= dec_pc_d;
            dec_instr_q <= dec_instr_d;
            stb_q       <= 1'b1;
        end
    end

    assign bus.o_iaddr    = pc_q;
    assign bus.o_pc       = dec_pc_q;
    assign bus.o_instr    = dec_instr_q;
    assign bus.o_imem_stb = stb_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed plus random bench for if_stage, checked against a rule-level fetch model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state: fetch address, decode pc/instr, strobe.
    logic [31:0] m_fetch;
    logic [31:0] m_dpc;
    logic [31:0] m_dinstr;
    logic        m_stb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch  = 32'h0;
        m_dpc    = 32'h0;
        m_dinstr = NOP;
        m_stb    = 1'b0;
    endtask

    // Apply the fetch rules for one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        logic [31:0] nf;
        logic [31:0] ndpc;
        logic [31:0] ninstr;
        logic        got;
        got    = m_stb && bus.i_imem_ack;
        nf     = m_fetch;
        ndpc   = m_dpc;
        ninstr = NOP;
        if (bus.i_jalr)      nf = {bus.i_result[31:1], 1'b0};
        else if (bus.i_boj)  nf = m_dpc + bus.i_imm;
        else if (got)        nf = m_fetch + 32'd4;
        if (!(bus.i_jalr || bus.i_boj) && got) begin
            ninstr = bus.i_inst;
            ndpc   = m_fetch;
        end
        m_fetch  = nf;
        m_dpc    = ndpc;
        m_dinstr = ninstr;
        m_stb    = 1'b1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".iaddr"}, bus.o_iaddr, m_fetch);
        chk({tag, ".pc"}, bus.o_pc, m_dpc);
        chk({tag, ".instr"}, bus.o_instr, m_dinstr);
        chk({tag, ".stb"}, {31'h0, bus.o_imem_stb}, {31'h0, m_stb});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic ack, input logic [31:0] inst, input logic boj,
                         input logic jalr, input logic [31:0] imm, input logic [31:0] res);
        bus.i_imem_ack = ack;
        bus.i_inst     = inst;
        bus.i_boj      = boj;
        bus.i_jalr     = jalr;
        bus.i_imm      = imm;
        bus.i_result   = res;
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] held;
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        #10;
        check_all("reset");
        chk("reset.nop_const", bus.o_instr, 32'h0000_0013);

        // Release between edges, strobe rises on the first edge.
        @(negedge clk);
        rst_n = 1'b0;
        step("release");
        chk("release.stb", {31'h0, bus.o_imem_stb}, 32'h1);

        drive(1'b1, 32'h0010_6293, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step("seq");
            chk("seq.addr", bus.o_iaddr, 32'(4 * (i + 1)));
        end
        chk("seq.instr", bus.o_instr, 32'h0010_6293);
        chk("seq.trail", bus.o_pc, bus.o_iaddr - 32'd4);

        // Single-cycle branch.
        p = m_dpc;
        drive(1'b1, 32'h0010_6293, 1'b1, 1'b0, 32'hC, 32'h0);
        step("boj");
        chk("boj.addr", bus.o_iaddr, p + 32'hC);
        chk("boj.nop", bus.o_instr, NOP);
        chk("boj.pc_held", bus.o_pc, p);

        // Held branch: second target still relative to the same decode pc.
        step("boj2");
        chk("boj2.addr", bus.o_iaddr, p + 32'hC);

        drive(1'b1, 32'h0010_6293, 1'b0, 1'b1, 32'h0, 32'hF);
        step("jalr");
        chk("jalr.addr", bus.o_iaddr, 32'hE);
        chk("jalr.nop", bus.o_instr, NOP);

        drive(1'b1, 32'h0010_6293, 1'b1, 1'b1, 32'h40, 32'hF);
        step("both");
        chk("both.addr", bus.o_iaddr, 32'hE);

        // Stall three cycles.
        drive(1'b1, 32'h0010_6293, 1'b0, 1'b0, 32'h0, 32'h0);
        step("pre_stall");
        held = bus.o_iaddr;
        p    = bus.o_pc;
        drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.addr", bus.o_iaddr, held);
            chk("stall.nop", bus.o_instr, NOP);
            chk("stall.pc", bus.o_pc, p);
        end
        drive(1'b1, 32'h0000_0093, 1'b0, 1'b0, 32'h0, 32'h0);
        step("resume");
        chk("resume.pc", bus.o_pc, held);
        chk("resume.addr", bus.o_iaddr, held + 32'd4);

        // Redirect with no ack, then a wraparound near 2^32.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
        step("boj_noack");
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFD);
        step("jalr_hi");
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0);
        step("wrap0");
        step("wrap1");
        chk("wrap.addr", bus.o_iaddr, 32'h0000_0004);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), $urandom_range(0, 63) - 32'd32, $urandom);
            step("rand");
        end

        // Asynchronous reset mid-cycle at fetch address 0x20.
        drive(1'b1, 32'h0010_6293, 1'b0, 1'b1, 32'h0, 32'h20);
        step("to20");
        chk("to20.addr", bus.o_iaddr, 32'h20);
        drive(1'b1, 32'h0010_6293, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b0;
        step("rerelease");
        step("refetch");
        chk("refetch.addr", bus.o_iaddr, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
